phy_rx_deser: RTL and testbench
===============================

Name: phy_rx_deser

Overview:
- Receive-side counterpart of the two-lane PHY transmitter.
- Samples serial lanes data_paralelo_serial_0/1 at bit rate and acquires symbol alignment on COM (0xBC) per lane.
- Strips COM/IDL control symbols and reassembles byte-striped lane data into 32-bit words with a valid strobe.
- Sits between the serial link and the receive-side recirculator / upper layer.

Parameters:
- COM_SYM, 8'hBC, comma / alignment symbol.
- IDL_SYM, 8'h7C, idle filler symbol.
- LOCK_COUNT, 4, consecutive aligned COMs required per lane to lock (legal range 2..15).

Ports:
- clk_32f  in  1  bit-rate clock, sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_paralelo_serial_0  in  1  serial lane 0, MSB first.
- data_paralelo_serial_1  in  1  serial lane 1, MSB first.
- data_output  out  32  reassembled word.
- valid_out  out  1  one-cycle strobe, data_output valid.
- active  out  1  both lanes locked and in phase.
- error  out  1  one-cycle pulse on symbol or bonding error.

Behaviour:
- Reset (reset=0, async): all outputs 0; shift registers 0; both lanes return to HUNT; bit counters 0; partial word cleared. Asserting reset mid-word discards the word; no valid_out is issued for it.
- Per-lane 8-bit shift register: shifts in 1 bit per cycle, MSB first.
- Per-lane FSM states: HUNT, CHECK, LOCKED.
  - HUNT: every cycle, compare the shift register (including the newest bit) to COM_SYM. On match: bit_cnt:=0, com_cnt:=1, go CHECK.
  - CHECK: at each 8-bit boundary (bit_cnt wraps 7->0), if symbol==COM_SYM then com_cnt++, else go HUNT. When com_cnt reaches LOCK_COUNT, go LOCKED.
  - LOCKED: held until reset; there is no loss-of-lock detection.
- Phase check: when both lanes are LOCKED with equal bit_cnt, active=1, registered. If both lanes are LOCKED with unequal bit_cnt: pulse error once, force both lanes to HUNT, active stays 0.
- Symbol decode: applies only while active=1, at the common boundary.
  - A symbol equal to COM_SYM or IDL_SYM is control (K); anything else is data (D).
- Word assembly: a half flag selects the half-word.
  - D/D pair with half=0: lane0 byte -> word[31:24], lane1 byte -> word[23:16]; half:=1.
  - D/D pair with half=1: lane0 -> [15:8], lane1 -> [7:0]; data_output updated, valid_out=1 for one cycle; half:=0.
  - K/K pair: no data. If half=1, the partial word is discarded, error pulses, half:=0.
  - D/K or K/D pair: error pulses, partial word discarded, half:=0.
- Latency: valid_out is asserted on the clock edge after the last bit of the second symbol pair is sampled.
- Throughput: at most one word per 16 clk_32f cycles.
- data_output holds its last value between strobes.

Optional Feature:
- Macro RX_ERR_CNT_EN.
- Defined:
  - Adds output err_count[7:0].
  - Saturating count of error pulses; sticks at 8'hFF.
  - Cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package phy_pkg: COM_SYM/IDL_SYM constants, lane FSM state encoding (HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2), bit-count width constant.
- One sub-module, phy_rx_lane_align, instantiated twice. It contains the shift register, bit counter, COM counter and lane FSM, and outputs symbol, boundary, locked and bit_cnt.
- The top level holds the phase check, decode, word assembly and error logic.

Test Plan:
1. Assert reset=0 with random lane toggling -> all outputs 0. Release reset -> outputs remain 0 until lock.
2. Four aligned BC symbols on both lanes, in phase -> active=1 on the edge after the 4th BC's final bit; error stays 0.
3. After lock, lane0 bytes DE then BE, lane1 bytes AD then EF -> data_output=32'hDEADBEEF with a single valid_out pulse 16 cycles after the first byte's first bit.
4. Lane1 COM stream offset by 3 bits from lane0 -> one error pulse, active stays 0. Re-sending aligned COMs then locks normally.
5. After lock, lane0 byte 12 with lane1 IDL 7C -> error pulse, no valid_out. The next D/D/D/D sequence 11,22,33,44 yields 32'h11223344.
6. Assert reset after only the first D/D pair of a word -> outputs 0 immediately. Relocking plus a full word produces exactly one valid_out. With RX_ERR_CNT_EN defined, 300 forced errors -> err_count=8'hFF.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared constants, lane alignment state encoding and symbol helpers for the
// two-lane PHY receive path.
package phy_pkg;

    localparam logic [7:0] COM_SYM_C = 8'hBC;
    localparam logic [7:0] IDL_SYM_C = 8'h7C;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lane_state_e;

    function automatic logic is_ctrl(input logic [7:0] sym,
                                     input logic [7:0] com,
                                     input logic [7:0] idl);
        return (sym == com) || (sym == idl);
    endfunction

endpackage

// File: rtl/phy_rx_lane_align.sv
// Per-lane bit sampler: MSB-first shift register, free-running bit counter and
// the HUNT/CHECK/LOCKED comma alignment FSM.
module phy_rx_lane_align
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM_SYM    = COM_SYM_C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 bit_i,
    input  logic                 force_hunt_i,
    output logic [7:0]           symbol_o,
    output logic                 boundary_o,
    output logic                 locked_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o
);

    localparam logic [3:0]           LOCK_C  = 4'(LOCK_COUNT);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_MAX = BIT_CNT_W'(7);

    lane_state_e          state_q;
    logic [7:0]           sr_q;
    logic [7:0]           sr_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [3:0]           com_cnt_q;
    logic [3:0]           com_cnt_inc;

    assign sr_d        = {sr_q[6:0], bit_i};
    assign com_cnt_inc = com_cnt_q + 4'd1;

    // bit_cnt_q == 0 means sr_q holds a symbol completed on the last edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
            if (force_hunt_i) begin
                state_q   <= HUNT;
                com_cnt_q <= '0;
            end else begin
                case (state_q)
                    HUNT: begin
                        if (sr_d == COM_SYM) begin
                            bit_cnt_q <= '0;
                            com_cnt_q <= 4'd1;
                            state_q   <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (bit_cnt_q == BIT_MAX) begin
                            if (sr_d == COM_SYM) begin
                                com_cnt_q <= com_cnt_inc;
                                if (com_cnt_inc == LOCK_C) begin
                                    state_q <= LOCKED;
                                end
                            end else begin
                                com_cnt_q <= '0;
                                state_q   <= HUNT;
                            end
                        end
                    end
                    LOCKED: begin
                        state_q <= LOCKED;
                    end
                    default: begin
                        state_q   <= HUNT;
                        com_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign symbol_o   = sr_q;
    assign boundary_o = (bit_cnt_q == '0);
    assign locked_o   = (state_q == LOCKED);
    assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/phy_rx_deser.sv
// Two-lane PHY receiver: lane alignment, inter-lane phase check, K/D decode and
// 32-bit word reassembly. Define RX_ERR_CNT_EN to add the err_count output.
module phy_rx_deser
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM_SYM    = COM_SYM_C,
    parameter logic [7:0]  IDL_SYM    = IDL_SYM_C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_paralelo_serial_0,
    input  logic        data_paralelo_serial_1,
    output logic [31:0] data_output,
    output logic        valid_out,
    output logic        active,
    output logic        error
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    logic [7:0]           sym0, sym1;
    logic                 bnd0, bnd1;
    logic                 lck0, lck1;
    logic [BIT_CNT_W-1:0] cnt0, cnt1;
    logic                 phase_err;

    logic        active_q, active_d;
    logic        error_q, error_d;
    logic        valid_q, valid_d;
    logic        half_q, half_d;
    logic [15:0] hi_q, hi_d;
    logic [31:0] data_q, data_d;
    logic        pair_ok, k0, k1;

    phy_rx_lane_align #(
        .COM_SYM    (COM_SYM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lane0 (
        .clk_i        (clk_32f),
        .rst_ni       (reset),
        .bit_i        (data_paralelo_serial_0),
        .force_hunt_i (phase_err),
        .symbol_o     (sym0),
        .boundary_o   (bnd0),
        .locked_o     (lck0),
        .bit_cnt_o    (cnt0)
    );

    phy_rx_lane_align #(
        .COM_SYM    (COM_SYM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lane1 (
        .clk_i        (clk_32f),
        .rst_ni       (reset),
        .bit_i        (data_paralelo_serial_1),
        .force_hunt_i (phase_err),
        .symbol_o     (sym1),
        .boundary_o   (bnd1),
        .locked_o     (lck1),
        .bit_cnt_o    (cnt1)
    );

    // Lanes locked on different bit phases cannot be bonded: restart both
    assign phase_err = lck0 && lck1 && (cnt0 != cnt1);
    assign active_d  = lck0 && lck1 && (cnt0 == cnt1);

    assign pair_ok = active_q && bnd0 && bnd1;
    assign k0      = is_ctrl(sym0, COM_SYM, IDL_SYM);
    assign k1      = is_ctrl(sym1, COM_SYM, IDL_SYM);

    always_comb begin
        half_d  = half_q;
        hi_d    = hi_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = phase_err;
        if (pair_ok) begin
            if (!k0 && !k1) begin
                if (!half_q) begin
                    hi_d   = {sym0, sym1};
                    half_d = 1'b1;
                end else begin
                    data_d  = {hi_q, sym0, sym1};
                    valid_d = 1'b1;
                    half_d  = 1'b0;
                end
            end else if (k0 && k1) begin
                // Control filler is legal only between words
                error_d = error_d | half_q;
                half_d  = 1'b0;
            end else begin
                error_d = 1'b1;
                half_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
            half_q   <= 1'b0;
            hi_q     <= '0;
            data_q   <= '0;
        end else begin
            active_q <= active_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
            half_q   <= half_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
        end
    end

    assign data_output = data_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign error       = error_q;

`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (error_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_phy_rx_deser.sv
// Randomized bench for phy_rx_deser against a symbol-level reference model.
module tb_phy_rx_deser;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l0, l1;
    logic [31:0] dout;
    logic        valid_out, active, error;
`ifdef RX_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    phy_rx_deser dut (
        .clk_32f                (clk),
        .reset                  (rst_n),
        .data_paralelo_serial_0 (l0),
        .data_paralelo_serial_1 (l1),
        .data_output            (dout),
        .valid_out              (valid_out),
        .active                 (active),
        .error                  (error)
`ifdef RX_ERR_CNT_EN
        ,
        .err_count              (err_count)
`endif
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int err_seen = 0;
    int exp_err  = 0;
    int n_valid  = 0;
    int n_exp_words = 0;
    int last_valid_cyc = -1;

    logic [31:0] exp_q[$];
    logic        m_half = 1'b0;
    logic [15:0] m_hi   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (error === 1'b1) err_seen++;
        if (valid_out === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() > 0) chk("word", dout, exp_q.pop_front());
            else chk("spurious_valid", {31'b0, valid_out}, 32'h0);
        end
    end

    // Symbol-pair rules applied to pairs that arrive while the link is active
    task automatic mdl_pair(input logic [7:0] b0, input logic [7:0] b1);
        bit k0, k1;
        k0 = (b0 == COM) || (b0 == IDL);
        k1 = (b1 == COM) || (b1 == IDL);
        if (!k0 && !k1) begin
            if (!m_half) begin
                m_hi   = {b0, b1};
                m_half = 1'b1;
            end else begin
                exp_q.push_back({m_hi, b0, b1});
                n_exp_words++;
                m_half = 1'b0;
            end
        end else if (k0 && k1) begin
            if (m_half) exp_err++;
            m_half = 1'b0;
        end else begin
            exp_err++;
            m_half = 1'b0;
        end
    endtask

    task automatic step_bits(input logic [63:0] v0, input logic [63:0] v1, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            l0 = v0[i];
            l1 = v1[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
        step_bits(64'(b0), 64'(b1), 8);
        mdl_pair(b0, b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_half = 1'b0;
        exp_q.delete();
        step_bits(64'h0, 64'h0, 3);
        rst_n = 1'b1;
        step_bits(64'h0, 64'h0, 5);
    endtask

    task automatic lock_seq(input string tag);
        for (int i = 0; i < 4; i++) step_bits(64'(COM), 64'(COM), 8);
        chk({tag, "_pre_active"}, {31'b0, active}, 32'h0);
        step_bits(64'(COM >> 7), 64'(COM >> 7), 1);
        chk({tag, "_active"}, {31'b0, active}, 32'h1);
        step_bits(64'(COM), 64'(COM), 7);
        mdl_pair(COM, COM);
        chk({tag, "_lock_err"}, 32'(err_seen), 32'(exp_err));
    endtask

    function automatic logic [7:0] rnd_byte();
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, v0, e0;
        rst_n = 1'b0;
        l0 = 1'b0;
        l1 = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset with toggling lanes, then idle after release
        for (int i = 0; i < 12; i++) begin
            l0 = 1'($urandom);
            l1 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_dout", dout, 32'h0);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_active", {31'b0, active}, 32'h0);
        chk("rst_error", {31'b0, error}, 32'h0);
        rst_n = 1'b1;
        step_bits(64'h0, 64'h0, 20);
        chk("idle_active", {31'b0, active}, 32'h0);
        chk("idle_dout", dout, 32'h0);

        // 2: aligned lock
        lock_seq("lock1");

        // 3: DEADBEEF with latency check
        t0 = cyc;
        v0 = n_valid;
        send_pair(8'hDE, 8'hAD);
        send_pair(8'hBE, 8'hEF);
        send_pair(COM, COM);
        chk("deadbeef_cnt", 32'(n_valid - v0), 32'h1);
        chk("deadbeef_lat", 32'(last_valid_cyc), 32'(t0 + 17));
        chk("deadbeef_hold", dout, 32'hDEADBEEF);

        // 5: mixed D/K pair, then a clean word
        send_pair(8'h12, IDL);
        send_pair(8'h11, 8'h22);
        send_pair(8'h33, 8'h44);
        send_pair(IDL, IDL);
        chk("mixed_err", 32'(err_seen), 32'(exp_err));
        chk("w11223344", dout, 32'h11223344);

        // randomized pair stream
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) send_pair(($urandom_range(0, 1) != 0) ? COM : IDL, IDL);
            else if (r == 1) send_pair(rnd_byte(), COM);
            else send_pair(rnd_byte(), rnd_byte());
        end
        send_pair(COM, COM);
        send_pair(COM, COM);
        chk("rand_err", 32'(err_seen), 32'(exp_err));
        chk("rand_words", 32'(n_valid), 32'(n_exp_words));
        chk("rand_q_empty", 32'(exp_q.size()), 32'h0);

        // 4: lane1 offset by 3 bits
        do_reset();
        e0 = err_seen;
        step_bits({29'h0, COM, COM, COM, COM, 3'b000}, {32'h0, COM, COM, COM, COM}, 35);
        step_bits(64'h0, 64'h0, 16);
        exp_err++;
        chk("phase_err", 32'(err_seen - e0), 32'h1);
        chk("phase_active", {31'b0, active}, 32'h0);
        lock_seq("relock");
        send_pair(8'hCA, 8'hFE);
        send_pair(8'hBA, 8'hBE);
        send_pair(COM, COM);
        chk("relock_word", dout, 32'hCAFEBABE);

        // 6: reset in the middle of a word
        send_pair(8'hDE, 8'hAD);
        step_bits(64'(8'hBE >> 5), 64'(8'hEF >> 5), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout, 32'h0);
        chk("midrst_active", {31'b0, active}, 32'h0);
        m_half = 1'b0;
        exp_q.delete();
        step_bits(64'h0, 64'h0, 3);
        rst_n = 1'b1;
        step_bits(64'h0, 64'h0, 5);
        v0 = n_valid;
        lock_seq("lock3");
        send_pair(8'h5A, 8'hA5);
        send_pair(8'h0F, 8'hF0);
        send_pair(COM, COM);
        chk("post_rst_cnt", 32'(n_valid - v0), 32'h1);
        chk("post_rst_word", dout, 32'h5AA50FF0);
        chk("post_rst_err", 32'(err_seen), 32'(exp_err));

`ifdef RX_ERR_CNT_EN
        do_reset();
        chk("errcnt_rst", {24'h0, err_count}, 32'h0);
        lock_seq("lock4");
        for (int i = 0; i < 300; i++) send_pair(8'h12, IDL);
        send_pair(COM, COM);
        chk("errcnt_sat", {24'h0, err_count}, 32'hFF);
        chk("errcnt_pulses", 32'(err_seen), 32'(exp_err));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
